bcd_operand_entry: RTL

Parametrised successor to the fixed two-operand, four-digit keypad entry logic. It captures keypad codes from the keypad decoder into OPERANDS BCD registers of DIGITS digits each. Digits enter at the least-significant end; the block supports backspace, clear, advance-to-next-operand and a result load-back path. It sits between the keypad decoder and the calculator, on the divided clock.

---
 rtl/bcd_operand_entry.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/bcd_operand_entry.sv
// bcd_operand_entry
//   Turns keypad decoder codes into BCD operand registers for the calculator.
//   There are OPERANDS registers of DIGITS BCD digits each. Digits shift in at
//   the least-significant end. The keys also provide backspace, clear and
//   advance-to-next-operand. A load path writes a result back into operand 0.
//   The block runs on the divided system clock.
//
//   Optional build macro KEY_DEBOUNCE_EN: adds a QUAL state. A key code must be
//   stable for DEBOUNCE cycles before it is acted on. A release must show
//   DEBOUNCE consecutive no-key cycles. Without the macro, DEBOUNCE is only
//   checked for legality.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous reset, active low
//   key         decoder code: 0-9 digit, 10 clear, 11 backspace, 12 next,
//               5'h1F no key, 13-30 consumed as a press with no action
//   load_en     load load_val into operand 0 and make operand 0 active
//   load_val    BCD value to load (stored verbatim)
//   operands    operand k at bits [4*DIGITS*(k+1)-1 : 4*DIGITS*k], digit 0 LSB
//   active_idx  operand currently being edited
//   digit_cnt   number of digits entered into the active operand
//   ovf         one-cycle pulse: digit dropped because the operand was full
//   entry_done  one-cycle pulse: next pressed on the last operand
//
// Observability: the key FSM state is held in the enum variable "state".

module bcd_operand_entry #(
    parameter int DIGITS   = 4,
    parameter int OPERANDS = 2,
    parameter int IDX_W    = 3,
    parameter int DEBOUNCE = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [4:0]                     key,
    input  logic                           load_en,
    input  logic [4*DIGITS-1:0]            load_val,
    output logic [4*DIGITS*OPERANDS-1:0]   operands,
    output logic [IDX_W-1:0]               active_idx,
    output logic [3:0]                     digit_cnt,
    output logic                           ovf,
    output logic                           entry_done
);

    localparam int W = 4 * DIGITS;

    localparam logic [4:0] KEY_NONE  = 5'h1F;
    localparam logic [4:0] KEY_CLEAR = 5'd10;
    localparam logic [4:0] KEY_BACK  = 5'd11;
    localparam logic [4:0] KEY_NEXT  = 5'd12;

    // Elaboration-time guard against unusable parameter sets.
    if (DIGITS < 1 || DIGITS > 8 || OPERANDS < 2 || OPERANDS > 8 ||
        (2 ** IDX_W) < OPERANDS || DEBOUNCE < 1) begin : g_bad_params
        $error("bcd_operand_entry: illegal parameter combination");
    end

`ifdef KEY_DEBOUNCE_EN
    localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    typedef enum logic [1:0] {S_IDLE, S_QUAL, S_HELD} state_t;
    logic [4:0]      code_q;   // code latched on entry to QUAL
    logic [DB_W-1:0] db_cnt;   // stability counter, shared by QUAL and HELD
`else
    typedef enum logic [0:0] {S_IDLE, S_HELD} state_t;
`endif

    state_t      state;
    logic [W-1:0] op_q  [OPERANDS];
    logic [3:0]   cnt_q [OPERANDS];

    logic [W-1:0] cur_op;
    logic [3:0]   cur_cnt;
    logic         fire;      // this edge performs the action of a press
    logic [4:0]   act_code;
    logic         take;      // action actually applied (load_en wins)

    // Active operand and its count.
    always_comb begin
        cur_op  = '0;
        cur_cnt = '0;
        for (int k = 0; k < OPERANDS; k++) begin
            if (active_idx == IDX_W'(k)) begin
                cur_op  = op_q[k];
                cur_cnt = cnt_q[k];
            end
        end
    end

`ifdef KEY_DEBOUNCE_EN
    // On the firing edge key still equals code_q, so code_q is the code acted on.
    assign fire     = (state == S_QUAL) && (key == code_q) &&
                      (db_cnt == DB_W'(DEBOUNCE - 1));
    assign act_code = code_q;
`else
    assign fire     = (state == S_IDLE) && (key != KEY_NONE);
    assign act_code = key;
`endif
    assign take = fire && !load_en;

    // Digit count of a loaded value: index of the highest nonzero digit + 1.
    function automatic logic [3:0] load_count(input logic [W-1:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] != 4'd0) c = 4'(i + 1);
        end
        return c;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            active_idx <= '0;
            ovf        <= 1'b0;
            entry_done <= 1'b0;
            for (int k = 0; k < OPERANDS; k++) begin
                op_q[k]  <= '0;
                cnt_q[k] <= '0;
            end
`ifdef KEY_DEBOUNCE_EN
            code_q <= KEY_NONE;
            db_cnt <= '0;
`endif
        end else begin
            ovf        <= 1'b0;
            entry_done <= 1'b0;

            // Key press tracking: one action per press.
`ifdef KEY_DEBOUNCE_EN
            case (state)
                S_IDLE: begin
                    if (key != KEY_NONE) begin
                        state  <= S_QUAL;
                        code_q <= key;
                        db_cnt <= '0;
                    end
                end
                S_QUAL: begin
                    if (key != code_q) begin
                        state <= S_IDLE;
                    end else if (fire) begin
                        state  <= S_HELD;
                        db_cnt <= '0;
                    end else begin
                        db_cnt <= db_cnt + DB_W'(1);
                    end
                end
                S_HELD: begin
                    // Any non-idle code restarts the release count.
                    if (key != KEY_NONE) begin
                        db_cnt <= '0;
                    end else if (db_cnt == DB_W'(DEBOUNCE - 1)) begin
                        state <= S_IDLE;
                    end else begin
                        db_cnt <= db_cnt + DB_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
`else
            case (state)
                S_IDLE:  if (key != KEY_NONE) state <= S_HELD;
                S_HELD:  if (key == KEY_NONE) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
`endif

            // Operand datapath
            if (load_en) begin
                op_q[0]    <= load_val;
                cnt_q[0]   <= load_count(load_val);
                active_idx <= '0;
            end else if (take) begin
                if (act_code <= 5'd9) begin
                    if (cur_cnt < 4'(DIGITS)) begin
                        for (int k = 0; k < OPERANDS; k++) begin
                            if (active_idx == IDX_W'(k)) begin
                                // Truncating the concatenation shifts left one digit.
                                op_q[k]  <= W'({cur_op, act_code[3:0]});
                                cnt_q[k] <= cur_cnt + 4'd1;
                            end
                        end
                    end else begin
                        ovf <= 1'b1;
                    end
                end else if (act_code == KEY_BACK) begin
                    if (cur_cnt != 4'd0) begin
                        for (int k = 0; k < OPERANDS; k++) begin
                            if (active_idx == IDX_W'(k)) begin
                                op_q[k]  <= cur_op >> 4;
                                cnt_q[k] <= cur_cnt - 4'd1;
                            end
                        end
                    end
                end else if (act_code == KEY_CLEAR) begin
                    for (int k = 0; k < OPERANDS; k++) begin
                        if (active_idx == IDX_W'(k)) begin
                            op_q[k]  <= '0;
                            cnt_q[k] <= '0;
                        end
                    end
                end else if (act_code == KEY_NEXT) begin
                    if (active_idx == IDX_W'(OPERANDS - 1)) begin
                        active_idx <= '0;
                        entry_done <= 1'b1;
                    end else begin
                        active_idx <= active_idx + IDX_W'(1);
                    end
                end
                // Codes 13-30 have no action.
            end
        end
    end

    for (genvar k = 0; k < OPERANDS; k++) begin : g_out
        assign operands[W*k +: W] = op_q[k];
    end

    assign digit_cnt = cur_cnt;

endmodule
